rtc_bus_sequencer: RTL and testbench
====================================

# rtc_bus_sequencer

Multiplexed address/data bus sequencer for the external RTC chip. It turns a one-cycle `start` request into a complete chip-select / address-latch / read-or-write strobe sequence on the 8-bit AD bus. On reads it samples the returned byte and presents it on `datos` with a one-cycle `enable` pulse. It sits directly upstream of the 8-bit synchronous capture register (`datos`/`enable` inputs), which holds the byte for the display logic.

## Interface
- T_ADDR, 4, cycles ALE held high with address driven (≥1)
- T_ACC, 6, cycles RD_n/WR_n held low (≥2)
- T_REC, 2, recovery cycles with CS_n high before the next transaction (≥1)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, sync active-high reset
- start  in  1  one-cycle transaction request, sampled only when busy=0
- wr  in  1  1 = write, 0 = read; sampled with start
- addr  in  8  RTC register address; sampled with start
- wdata  in  8  write data; sampled with start
- ad_in  in  8  AD bus input from pad
- ad_out  out  8  AD bus output to pad
- ad_oe  out  1  pad output enable (1 = drive ad_out)
- cs_n  out  1  chip select, active low
- ale  out  1  address latch enable, active high
- rd_n  out  1  read strobe, active low
- wr_n  out  1  write strobe, active low
- datos  out  8  last byte read; feeds capture register
- enable  out  1  one-cycle strobe: datos is new
- busy  out  1  transaction in progress

## Operation
- All outputs are registered. Reset values: ad_out=8'h00, ad_oe=0, cs_n=1, ale=0, rd_n=1, wr_n=1, datos=8'h00, enable=0, busy=0, FSM=IDLE.
- FSM states are IDLE, ADDR, HOLD, ACC, REC. A single down-counter, sized for max(T_ADDR,T_ACC,T_REC), times each state.
- IDLE: when start=1, latch wr/addr/wdata and go to ADDR. Outputs stay at their reset values.
- ADDR (T_ADDR cycles): cs_n=0, ale=1, ad_oe=1, ad_out=addr.
- HOLD (1 cycle): ale=0. Address stays driven and cs_n=0.
- ACC (T_ACC cycles):
  - Read: ad_oe=0, rd_n=0.
  - Write: ad_oe=1, ad_out=wdata, wr_n=0.
- Read sampling: ad_in is captured into datos on the final ACC edge. enable=1 for exactly the next cycle, which is the first REC cycle. datos holds until the next read completes.
- Writes never pulse enable and never change datos.
- REC (T_REC cycles): cs_n=1, rd_n=1, wr_n=1, ad_oe=0. The FSM then returns to IDLE.
- start while busy=1 is ignored and not queued.
- reset has priority over everything, including a start in the same cycle. Reset mid-transaction returns all outputs to their reset values on the next edge. datos is cleared, and no enable pulse is emitted.
- rd_n and wr_n are never low simultaneously. ad_oe is never 1 while rd_n=0.

## Timing
- Start is sampled at edge 0. ADDR outputs appear after edge 0.
- busy goes high the cycle after start and stays high through the last REC cycle. It is low in the cycle where IDLE can accept a new start.
- Total transaction length is N = T_ADDR + 1 + T_ACC + T_REC cycles. With defaults, N = 13.
- Read latency from start to enable is T_ADDR + 1 + T_ACC + 1 cycles. With defaults, enable is high in cycle 12.
- Back-to-back: a start asserted in the first cycle where busy=0 begins the next transaction immediately. The minimum request spacing is N+1 edges.
- The strobe edges (cs_n, ale, rd_n, wr_n) change only on state boundaries. There are no glitches because all of them are registered.

## Structure
- Shared package/header holds:
  - state encoding localparams (IDLE=0, ADDR=1, HOLD=2, ACC=3, REC=4);
  - default T_ADDR/T_ACC/T_REC;
  - RTC register address constants (seconds, minutes, hours, …) shared with the top-level controller.
- The block is a single module with no sub-module. The pad tri-state (ad_oe/ad_out/ad_in) is resolved at top level, not inside this block.

## Test plan
- Read: reset 2 cycles, start with wr=0, addr=8'h21, bus model returns 8'h5A during rd_n=0 → ale high for cycles 1–4 with ad_out=21, rd_n low for cycles 6–11, datos=5A with enable=1 in cycle 12 only, busy low by cycle 14.
- Write: start with wr=1, addr=8'h22, wdata=8'hF6 → wr_n low for 6 cycles with ad_out=F6 and ad_oe=1, enable never high, datos unchanged.
- Busy lockout: second start (addr=8'h33) 3 cycles after the first → ignored, only one ALE burst observed.
- Reset mid-ACC of a read returning 8'hD3 → next edge has cs_n=1, rd_n=1, busy=0, datos=00, and no enable pulse.
- Simultaneous reset and start → block stays IDLE, no cs_n activity.
- Back-to-back reads of 8'h83 then 8'h88 with start asserted on the first busy=0 cycle → two enable pulses exactly N+1 cycles apart, datos=83 then 88, and the protocol invariants (rd_n/wr_n exclusivity, no ad_oe during rd_n) checked every cycle.

Source files
------------

// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared constants for the RTC multiplexed-bus sequencer and its controller.
package rtc_bus_sequencer_pkg;

   // FSM state encoding
   localparam logic [2:0] StateIdle = 3'd0;
   localparam logic [2:0] StateAddr = 3'd1;
   localparam logic [2:0] StateHold = 3'd2;
   localparam logic [2:0] StateAcc  = 3'd3;
   localparam logic [2:0] StateRec  = 3'd4;

   typedef enum logic [2:0] {
      StIdle = StateIdle,
      StAddr = StateAddr,
      StHold = StateHold,
      StAcc  = StateAcc,
      StRec  = StateRec
   } state_e;

   // Default phase lengths in clock cycles
   localparam int unsigned DefTAddr = 4;
   localparam int unsigned DefTAcc  = 6;
   localparam int unsigned DefTRec  = 2;

   // RTC register map, shared with the top-level controller
   localparam logic [7:0] RegSeconds = 8'h21;
   localparam logic [7:0] RegMinutes = 8'h22;
   localparam logic [7:0] RegHours   = 8'h23;
   localparam logic [7:0] RegDay     = 8'h24;
   localparam logic [7:0] RegMonth   = 8'h25;
   localparam logic [7:0] RegYear    = 8'h26;
   localparam logic [7:0] RegControl = 8'h2F;

   // Width of a down-counter that must hold max(a,b,c)-1
   function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Request side and pad side of the RTC bus sequencer, bundled as one interface.
interface rtc_bus_sequencer_if;
   logic       start;
   logic       wr;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic [7:0] ad_in;
   logic [7:0] ad_out;
   logic       ad_oe;
   logic       cs_n;
   logic       ale;
   logic       rd_n;
   logic       wr_n;
   logic [7:0] datos;
   logic       enable;
   logic       busy;

   // The sequencer itself
   modport slave (
      input  start, wr, addr, wdata, ad_in,
      output ad_out, ad_oe, cs_n, ale, rd_n, wr_n, datos, enable, busy
   );

   // Requester plus pad/chip model
   modport master (
      output start, wr, addr, wdata, ad_in,
      input  ad_out, ad_oe, cs_n, ale, rd_n, wr_n, datos, enable, busy
   );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Turns a one-cycle start into a CS/ALE/RD-or-WR strobe sequence on the RTC AD bus.
// Every output is a flop loaded from the next-state decode, so strobes are glitch-free.
module rtc_bus_sequencer
   import rtc_bus_sequencer_pkg::*;
#(
   parameter int unsigned T_ADDR = DefTAddr,
   parameter int unsigned T_ACC  = DefTAcc,
   parameter int unsigned T_REC  = DefTRec
) (
   input logic               clk,
   input logic               reset,
   rtc_bus_sequencer_if.slave bus
);

   localparam int unsigned CntW = cnt_width(T_ADDR, T_ACC, T_REC);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              is_wr_q, is_wr_d;
   logic [7:0]        addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;

   logic [7:0]        ad_out_q, ad_out_d;
   logic              ad_oe_q, ad_oe_d;
   logic              cs_n_q, cs_n_d;
   logic              ale_q, ale_d;
   logic              rd_n_q, rd_n_d;
   logic              wr_n_q, wr_n_d;
   logic [7:0]        datos_q, datos_d;
   logic              enable_q, enable_d;
   logic              busy_q, busy_d;

   // Next state, phase counter, request latch and read capture
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_wr_d  = is_wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      datos_d  = datos_q;
      enable_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StAddr;
               cnt_d   = CntW'(T_ADDR - 1);
               is_wr_d = bus.wr;
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
            end
         end
         StAddr: begin
            if (cnt_q == '0) state_d = StHold;
            else             cnt_d   = cnt_q - 1'b1;
         end
         StHold: begin
            state_d = StAcc;
            cnt_d   = CntW'(T_ACC - 1);
         end
         StAcc: begin
            if (cnt_q == '0) begin
               state_d = StRec;
               cnt_d   = CntW'(T_REC - 1);
               // Byte is sampled on the edge that ends the strobe
               if (!is_wr_q) begin
                  datos_d  = bus.ad_in;
                  enable_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StRec: begin
            if (cnt_q == '0) state_d = StIdle;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Pad and strobe values for the state being entered
   always_comb begin
      ad_out_d = 8'h00;
      ad_oe_d  = 1'b0;
      cs_n_d   = 1'b1;
      ale_d    = 1'b0;
      rd_n_d   = 1'b1;
      wr_n_d   = 1'b1;
      busy_d   = (state_d != StIdle);
      unique case (state_d)
         StAddr: begin
            cs_n_d   = 1'b0;
            ale_d    = 1'b1;
            ad_oe_d  = 1'b1;
            ad_out_d = addr_d;
         end
         StHold: begin
            cs_n_d   = 1'b0;
            ad_oe_d  = 1'b1;
            ad_out_d = addr_d;
         end
         StAcc: begin
            cs_n_d = 1'b0;
            if (is_wr_d) begin
               ad_oe_d  = 1'b1;
               ad_out_d = wdata_d;
               wr_n_d   = 1'b0;
            end else begin
               rd_n_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         is_wr_q  <= 1'b0;
         addr_q   <= 8'h00;
         wdata_q  <= 8'h00;
         ad_out_q <= 8'h00;
         ad_oe_q  <= 1'b0;
         cs_n_q   <= 1'b1;
         ale_q    <= 1'b0;
         rd_n_q   <= 1'b1;
         wr_n_q   <= 1'b1;
         datos_q  <= 8'h00;
         enable_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_wr_q  <= is_wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         ad_out_q <= ad_out_d;
         ad_oe_q  <= ad_oe_d;
         cs_n_q   <= cs_n_d;
         ale_q    <= ale_d;
         rd_n_q   <= rd_n_d;
         wr_n_q   <= wr_n_d;
         datos_q  <= datos_d;
         enable_q <= enable_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.ad_out = ad_out_q;
   assign bus.ad_oe  = ad_oe_q;
   assign bus.cs_n   = cs_n_q;
   assign bus.ale    = ale_q;
   assign bus.rd_n   = rd_n_q;
   assign bus.wr_n   = wr_n_q;
   assign bus.datos  = datos_q;
   assign bus.enable = enable_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: directed scenarios followed by randomized transactions,
// all outputs compared each cycle against a cycle-index model of one transaction.
module tb_rtc_bus_sequencer;
   import rtc_bus_sequencer_pkg::*;

   localparam int TA = 4;
   localparam int TC = 6;
   localparam int TR = 2;
   localparam int N  = TA + 1 + TC + TR;

   logic clk = 1'b0;
   logic reset = 1'b1;

   rtc_bus_sequencer_if bus ();

   rtc_bus_sequencer #(
      .T_ADDR (TA),
      .T_ACC  (TC),
      .T_REC  (TR)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: k is the 1-based cycle number inside a transaction, 0 when idle
   int         k = 0;
   logic       m_wr = 1'b0;
   logic [7:0] m_addr = 8'h00;
   logic [7:0] m_wdata = 8'h00;
   logic [7:0] m_datos = 8'h00;
   logic       m_enable = 1'b0;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         ale_bursts = 0;
   logic       prev_ale = 1'b0;
   int         en_cyc[$];
   logic [7:0] en_dat[$];
   logic [7:0] rdata = 8'h00;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic check_outputs();
      logic e_cs, e_ale, e_oe, e_rd, e_wr;
      logic [7:0] e_ad;
      e_cs = 1'b1; e_ale = 1'b0; e_oe = 1'b0; e_rd = 1'b1; e_wr = 1'b1; e_ad = 8'h00;
      if (k >= 1 && k <= TA) begin
         e_cs = 1'b0; e_ale = 1'b1; e_oe = 1'b1; e_ad = m_addr;
      end else if (k == TA + 1) begin
         e_cs = 1'b0; e_oe = 1'b1; e_ad = m_addr;
      end else if (k >= TA + 2 && k <= TA + 1 + TC) begin
         e_cs = 1'b0;
         if (m_wr) begin
            e_oe = 1'b1; e_ad = m_wdata; e_wr = 1'b0;
         end else begin
            e_rd = 1'b0;
         end
      end
      chk("cs_n", bus.cs_n, e_cs);
      chk("ale", bus.ale, e_ale);
      chk("ad_oe", bus.ad_oe, e_oe);
      chk("rd_n", bus.rd_n, e_rd);
      chk("wr_n", bus.wr_n, e_wr);
      chk("busy", bus.busy, (k != 0));
      chk("enable", bus.enable, m_enable);
      chk("datos", bus.datos, m_datos);
      if (e_oe || k == 0) chk("ad_out", bus.ad_out, e_ad);
      chk("strobe_excl", !(bus.rd_n === 1'b0 && bus.wr_n === 1'b0), 1'b1);
      chk("oe_during_rd", !(bus.rd_n === 1'b0 && bus.ad_oe === 1'b1), 1'b1);
   endtask

   // One clock: advance the model with the pre-edge inputs, then check
   task automatic step();
      logic s_rst, s_start, s_wr;
      logic [7:0] s_addr, s_wdata, s_adin;
      s_rst = reset; s_start = bus.start; s_wr = bus.wr;
      s_addr = bus.addr; s_wdata = bus.wdata; s_adin = bus.ad_in;
      @(posedge clk);
      #1;
      cyc++;
      if (s_rst) begin
         k = 0; m_datos = 8'h00; m_enable = 1'b0;
      end else begin
         m_enable = 1'b0;
         if (k == 0) begin
            if (s_start) begin
               k = 1; m_wr = s_wr; m_addr = s_addr; m_wdata = s_wdata;
            end
         end else begin
            if (k == TA + 1 + TC && !m_wr) begin
               m_datos = s_adin; m_enable = 1'b1;
            end
            k = (k == N) ? 0 : k + 1;
         end
      end
      check_outputs();
      if (bus.ale === 1'b1 && prev_ale === 1'b0) ale_bursts++;
      prev_ale = bus.ale;
      if (bus.enable === 1'b1) begin
         en_cyc.push_back(cyc);
         en_dat.push_back(bus.datos);
      end
      // Chip model: returns its byte only while RD_n is low
      bus.ad_in = (bus.rd_n === 1'b0) ? rdata : 8'($urandom);
   endtask

   task automatic start_txn(input logic w, input logic [7:0] a, input logic [7:0] d);
      bus.start = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = d;
      step();
      bus.start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy !== 1'b0 && n < 3 * N) begin
         step();
         n++;
      end
      chk("idle_timeout", bus.busy, 1'b0);
   endtask

   initial begin
      int s_cyc;
      int n_en;
      bus.start = 1'b0; bus.wr = 1'b0; bus.addr = 8'h00; bus.wdata = 8'h00; bus.ad_in = 8'h00;

      // Reset for two cycles
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      chk("reset_datos", bus.datos, 8'h00);
      chk("reset_cs_n", bus.cs_n, 1'b1);

      // Read of 0x21 returning 0x5A
      rdata = 8'h5A;
      ale_bursts = 0;
      start_txn(1'b0, RegSeconds, 8'h00);
      s_cyc = cyc;
      wait_idle();
      chk("read_enable_count", 8'(en_cyc.size()), 8'd1);
      if (en_cyc.size() == 1) begin
         chk("read_latency", 8'(en_cyc[0] - s_cyc), 8'(TA + 1 + TC));
         chk("read_data", en_dat[0], 8'h5A);
      end
      chk("read_busy_low_cycle", 8'(cyc - s_cyc), 8'(N));
      chk("read_ale_bursts", 8'(ale_bursts), 8'd1);

      // Write of 0xF6 to 0x22
      step();
      n_en = en_cyc.size();
      start_txn(1'b1, RegMinutes, 8'hF6);
      wait_idle();
      chk("write_no_enable", 8'(en_cyc.size() - n_en), 8'd0);
      chk("write_datos_kept", bus.datos, 8'h5A);

      // Second start three cycles in is ignored
      ale_bursts = 0;
      rdata = 8'h11;
      start_txn(1'b0, RegHours, 8'h00);
      step();
      step();
      bus.start = 1'b1; bus.wr = 1'b1; bus.addr = 8'h33; bus.wdata = 8'h99;
      step();
      bus.start = 1'b0;
      wait_idle();
      step();
      step();
      chk("lockout_ale_bursts", 8'(ale_bursts), 8'd1);
      chk("lockout_datos", bus.datos, 8'h11);

      // Reset in the middle of ACC on a read of 0xD3
      rdata = 8'hD3;
      n_en = en_cyc.size();
      start_txn(1'b0, RegDay, 8'h00);
      while (k < TA + 4) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midacc_busy", bus.busy, 1'b0);
      chk("midacc_datos", bus.datos, 8'h00);
      for (int i = 0; i < N; i++) step();
      chk("midacc_no_enable", 8'(en_cyc.size() - n_en), 8'd0);

      // Reset and start together: nothing happens
      ale_bursts = 0;
      reset = 1'b1;
      bus.start = 1'b1; bus.wr = 1'b0; bus.addr = RegMonth;
      step();
      reset = 1'b0;
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("rst_start_no_ale", 8'(ale_bursts), 8'd0);

      // Back-to-back reads, second start on the first busy=0 cycle
      en_cyc.delete();
      en_dat.delete();
      rdata = 8'h83;
      start_txn(1'b0, RegYear, 8'h00);
      wait_idle();
      rdata = 8'h88;
      start_txn(1'b0, RegControl, 8'h00);
      wait_idle();
      chk("b2b_enable_count", 8'(en_cyc.size()), 8'd2);
      if (en_cyc.size() == 2) begin
         chk("b2b_spacing", 8'(en_cyc[1] - en_cyc[0]), 8'(N + 1));
         chk("b2b_first", en_dat[0], 8'h83);
         chk("b2b_second", en_dat[1], 8'h88);
      end

      // Randomized transactions with stray starts while busy
      for (int t = 0; t < 25; t++) begin
         int gap;
         rdata = 8'($urandom);
         start_txn(1'($urandom), 8'($urandom), 8'($urandom));
         while (bus.busy === 1'b1 && k != 0) begin
            bus.start = ($urandom_range(0, 5) == 0);
            bus.wr = 1'($urandom);
            bus.addr = 8'($urandom);
            bus.wdata = 8'($urandom);
            step();
         end
         bus.start = 1'b0;
         wait_idle();
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
